// File: rtl/pattern_access_arbiter.sv
// pattern_access_arbiter: round-robin access to a shared pipelined pattern netlist, one transaction at a time
module pattern_access_arbiter #(
  parameter int NREQ    = 2,
  parameter int IN_W    = 11,
  parameter int OUT_W   = 11,
  parameter int LATENCY = 2
) (
  input  logic                 blif_clk_net,
  input  logic                 blif_reset_net,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*IN_W-1:0] req_vec,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [OUT_W-1:0]     rsp_vec,
  output logic [IN_W-1:0]      pat_in,
  input  logic [OUT_W-1:0]     pat_out,
  output logic                 busy,
  output logic [15:0]          txn_cnt
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [GW-1:0]   last_grant_q, owner_q, grant;
  logic [CW-1:0]   cnt_q;
  logic [IN_W-1:0] pat_in_q, sel_vec;
  logic [OUT_W-1:0] rsp_vec_q;
  logic [15:0]     txn_cnt_q;
  logic            accept;
  int              best, d;

  // Round-robin search: distance 0 is the requester right after the last grant
  always_comb begin
    best    = NREQ;
    d       = 0;
    grant   = '0;
    sel_vec = '0;
    for (int i = 0; i < NREQ; i++) begin
      d = (i + 2 * NREQ - 1 - int'(last_grant_q)) % NREQ;
      if (req_valid[i] && d < best) begin
        best    = d;
        grant   = GW'(i);
        sel_vec = req_vec[i*IN_W +: IN_W];
      end
    end
    accept = (state_q == IDLE) && (best < NREQ);
  end

  // Next state: capture after LATENCY+1 drive edges, release only on the owner's rsp_ready
  always_comb begin
    state_d = (state_q == IDLE)  ? (accept ? DRIVE : IDLE) :
              (state_q == DRIVE) ? ((cnt_q == CW'(LATENCY)) ? RESP : DRIVE) :
                                   (rsp_ready[owner_q] ? IDLE : RESP);
  end

  // Transaction state; the count holds at LATENCY on the capture edge so it never wraps
  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      state_q      <= IDLE;
      pat_in_q     <= '0;
      rsp_vec_q    <= '0;
      txn_cnt_q    <= '0;
      cnt_q        <= '0;
      owner_q      <= '0;
      last_grant_q <= GW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      if (accept) begin
        pat_in_q     <= sel_vec;
        owner_q      <= grant;
        last_grant_q <= grant;
        cnt_q        <= '0;
      end
      if (state_q == DRIVE) begin
        cnt_q <= (cnt_q == CW'(LATENCY)) ? cnt_q : cnt_q + 1'b1;
        if (cnt_q == CW'(LATENCY)) rsp_vec_q <= pat_out;
      end
      if (state_q == RESP && rsp_ready[owner_q] && txn_cnt_q != 16'hFFFF) txn_cnt_q <= txn_cnt_q + 1'b1;
    end
  end

  assign req_ready = (accept && !blif_reset_net) ? NREQ'(1) << grant : '0;
  assign rsp_valid = (state_q == RESP) ? NREQ'(1) << owner_q : '0;
  assign busy      = state_q != IDLE;
  assign pat_in    = pat_in_q;
  assign rsp_vec   = rsp_vec_q;
  assign txn_cnt   = txn_cnt_q;
endmodule

// File: tb/tb_pattern_access_arbiter.sv
// tb_pattern_access_arbiter: scoreboard bench for pattern_access_arbiter
module tb_pattern_access_arbiter;
  logic        clk = 0, rst = 1;
  logic [1:0]  req_valid = '0, rsp_ready = '0, req_ready, rsp_valid;
  logic [21:0] req_vec = '0;
  logic [10:0] rsp_vec, pat_in, pat_out, p1 = '0, p2 = '0;
  logic        busy;
  logic [15:0] txn_cnt;

  typedef struct packed {logic own; logic [10:0] vec;} exp_t;
  exp_t q[$];
  exp_t e_m;
  int   n_cmp = 0, n_fail = 0, cyc = 0, last_pres = -1, n_pres = 0;
  bit   per_en = 0;
  logic [1:0] prev_rv = '0;

  always #5 clk = ~clk;

  pattern_access_arbiter dut (
    .blif_clk_net(clk), .blif_reset_net(rst), .req_valid(req_valid), .req_vec(req_vec),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_vec(rsp_vec),
    .pat_in(pat_in), .pat_out(pat_out), .busy(busy), .txn_cnt(txn_cnt)
  );

  function automatic logic [10:0] f(input logic [10:0] x);
    return {x[9:0], x[10]} ^ 11'h2C3;
  endfunction

  // Two-stage model of the shared pattern netlist
  always @(posedge clk) begin
    p1 <= f(pat_in);
    p2 <= p1;
  end
  assign pat_out = p2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic own, input logic [10:0] v);
    q.push_back(exp_t'{own: own, vec: f(v)});
  endtask

  // Monitor: pops one expectation each time a new response is presented
  always @(negedge clk) begin
    cyc++;
    if (rsp_valid != 2'b00 && prev_rv == 2'b00) begin
      n_pres++;
      if (q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      else begin
        e_m = q.pop_front();
        chk("rsp_owner", 32'(rsp_valid), 32'(2'b01 << e_m.own));
        chk("rsp_vec", 32'(rsp_vec), 32'(e_m.vec));
      end
      if (per_en && last_pres >= 0) chk("period", 32'(cyc - last_pres), 32'd5);
      last_pres = cyc;
    end
    prev_rv = rsp_valid;
  end

  task automatic wait_pres(input int target);
    int k = 0;
    while (n_pres < target && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("wait_pres", 32'(n_pres), 32'(target));
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
  endtask

  task automatic run_txn(input int r, input logic [10:0] v, input logic [15:0] exp_cnt);
    req_vec[r*11 +: 11] = v;
    req_valid = 2'b01 << r;
    rsp_ready = 2'b01 << r;
    push(1'(r), v);
    @(posedge clk); #1;
    chk("txn_accept", 32'(busy), 32'd1);
    req_valid = '0;
    wait_idle();
    chk("txn_cnt", 32'(txn_cnt), 32'(exp_cnt));
    rsp_ready = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 2'b01;
    #1;
    chk("rst_pat_in", 32'(pat_in), 0);
    chk("rst_rsp_vec", 32'(rsp_vec), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_txn_cnt", 32'(txn_cnt), 0);
    req_valid = '0;
    @(negedge clk); rst = 0;
    // Single requester 0 transaction with latency boundary checks
    @(negedge clk);
    req_vec[10:0] = 11'h155;
    req_valid = 2'b01;
    #1 chk("t1_req_ready", 32'(req_ready), 32'h1);
    push(1'b0, 11'h155);
    @(posedge clk); #1;
    chk("t1_pat_in", 32'(pat_in), 32'h155);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_ready_drive", 32'(req_ready), 0);
    req_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t1_no_rsp_early", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_pat_in_resp", 32'(pat_in), 32'h155);
    rsp_ready = 2'b01;
    @(posedge clk); #1;
    chk("t1_txn_cnt", 32'(txn_cnt), 1);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_pat_in_idle", 32'(pat_in), 32'h155);
    rsp_ready = '0;
    // Both requesters held valid: alternating grants every LATENCY+3 cycles
    rst = 1; #1 rst = 0;
    req_vec = {11'h35E, 11'h0A1};
    push(1'b0, 11'h0A1); push(1'b1, 11'h35E); push(1'b0, 11'h0A1); push(1'b1, 11'h35E);
    last_pres = -1;
    per_en = 1;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    wait_pres(n_pres + 4);
    per_en = 0;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("t2_txn_cnt", 32'(txn_cnt), 4);
    chk("t2_idle", 32'(busy), 0);
    // Requester 1 only, response stalled with a non-owner rsp_ready
    req_vec[21:11] = 11'h2AA;
    req_valid = 2'b10;
    rsp_ready = 2'b01;
    push(1'b1, 11'h2AA);
    @(posedge clk); #1;
    chk("t3_busy", 32'(busy), 1);
    req_valid = '0;
    for (int k = 0; k < 10 && rsp_valid == 2'b00; k++) begin
      @(posedge clk); #1;
    end
    repeat (10) begin
      @(posedge clk); #1;
      chk("t3_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("t3_rsp_vec", 32'(rsp_vec), 32'(f(11'h2AA)));
      chk("t3_req_ready", 32'(req_ready), 0);
      chk("t3_busy_hold", 32'(busy), 1);
    end
    rsp_ready = 2'b10;
    @(posedge clk); #1;
    chk("t3_txn_cnt", 32'(txn_cnt), 5);
    chk("t3_idle", 32'(busy), 0);
    rsp_ready = '0;
    // Reset during DRIVE abandons the transaction; first accept on the first edge after release
    rst = 1; #1 rst = 0;
    req_vec[10:0] = 11'h0F0;
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = '0;
    chk("t4_busy", 32'(busy), 1);
    @(posedge clk); #1;
    #1 rst = 1;
    req_valid = 2'b01;
    #1;
    chk("t4_pat_in", 32'(pat_in), 0);
    chk("t4_rsp_vec", 32'(rsp_vec), 0);
    chk("t4_rsp_valid", 32'(rsp_valid), 0);
    chk("t4_req_ready", 32'(req_ready), 0);
    chk("t4_busy_rst", 32'(busy), 0);
    chk("t4_txn_cnt", 32'(txn_cnt), 0);
    push(1'b0, 11'h0F0);
    rsp_ready = 2'b01;
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    chk("t4_first_accept", 32'(busy), 1);
    chk("t4_pat_in_acc", 32'(pat_in), 32'h0F0);
    req_valid = '0;
    wait_idle();
    chk("t4_txn_cnt_after", 32'(txn_cnt), 1);
    rsp_ready = '0;
    // Saturation of the transaction counter
    @(negedge clk);
    force dut.txn_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.txn_cnt_q;
    #1 chk("t5_preload", 32'(txn_cnt), 32'hFFFE);
    run_txn(0, 11'h001, 16'hFFFF);
    run_txn(1, 11'h7FF, 16'hFFFF);
    run_txn(0, 11'h4C3, 16'hFFFF);
    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pattern_access_arbiter.md
PATTERN_ACCESS_ARBITER -- requirements
Module: pattern_access_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NREQ  2  number of requesters
  IN_W  11  stimulus width of the shared pattern netlist
  OUT_W  11  response width of the shared pattern netlist
  LATENCY  2  register stages between pattern netlist inputs and outputs, minimum 1
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  blif_clk_net  in  1  single clock; all state updates on the rising edge
  blif_reset_net  in  1  asynchronous, active-high reset
  req_valid  in  NREQ  request pending, one bit per requester
  req_vec  in  NREQ*IN_W  stimulus; requester i on bits [i*IN_W +: IN_W]
  req_ready  out  NREQ  request accepted this cycle
  rsp_valid  out  NREQ  response available to requester i
  rsp_ready  in  NREQ  requester i consumes the response
  rsp_vec  out  OUT_W  captured response, shared by all requesters
  pat_in  out  IN_W  drive to the shared pattern netlist inputs
  pat_out  in  OUT_W  pattern netlist outputs
  busy  out  1  high in every state except IDLE
  txn_cnt  out  16  completed transactions, saturating

Function
REQ-003 The block SHALL implement an FSM with states IDLE, DRIVE and RESP; exactly one transaction SHALL be outstanding at a time.
REQ-004 In IDLE, the arbiter SHALL grant the first requester with req_valid=1, searching round-robin from (last_grant+1) mod NREQ.
REQ-005 In IDLE, req_ready SHALL be one-hot combinational on the granted index and all-zero when no requester is valid; an accept is req_valid&req_ready.
REQ-006 req_ready SHALL be all-zero in DRIVE and RESP.
REQ-007 On the accept edge, the block SHALL latch req_vec[grant] into pat_in, record owner=grant, update last_grant=grant, clear cnt, and move to DRIVE.
REQ-008 In DRIVE, pat_in SHALL hold stable and cnt SHALL increment each cycle.
REQ-009 On the DRIVE edge where cnt==LATENCY, the block SHALL load pat_out into rsp_vec and move to RESP, so the last accept-to-capture window is LATENCY+1 edges.
REQ-010 In RESP, rsp_valid[owner] SHALL be 1, all other rsp_valid bits SHALL be 0, and rsp_vec SHALL hold stable.
REQ-011 On the first edge with rsp_ready[owner]=1 in RESP, the block SHALL return to IDLE and increment txn_cnt, saturating at 16'hFFFF.
REQ-012 rsp_ready bits of non-owners SHALL be ignored.
REQ-013 A requester SHALL NOT be accepted again in the IDLE cycle immediately following its own response; the round-robin pointer excludes it whenever another requester is valid.
REQ-014 When only one requester is valid, that requester SHALL be granted every transaction (back-to-back).
REQ-015 pat_in SHALL keep its last driven value in IDLE and RESP.
REQ-016 Deassertion of req_valid after accept SHALL have no effect on the transaction in flight.
REQ-017 cnt width SHALL be clog2(LATENCY+1); no wrap SHALL occur within DRIVE.

Reset
REQ-018 Asserting blif_reset_net SHALL immediately force state=IDLE, pat_in=0, rsp_vec=0, rsp_valid=0, req_ready=0, busy=0, txn_cnt=0, cnt=0, owner=0 and last_grant=NREQ-1, so requester 0 wins first.
REQ-019 Reset mid-transaction SHALL abandon the transaction with no response and no count increment.
REQ-020 After reset deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-021 The bench SHALL cover: reset release, then req_valid=2'b01 with vec0=11'h155 -> accept at edge E0, pat_in=11'h155 after E0, rsp_valid=2'b01 after edge E0+3 with rsp_vec equal to the pat_out sampled at that edge, txn_cnt=1 after rsp_ready.
REQ-022 The bench SHALL cover: req_valid=2'b11 held continuously with rsp_ready=2'b11 -> grants alternate 0,1,0,1, with one transaction every LATENCY+3 cycles.
REQ-023 The bench SHALL cover: rsp_ready held 0 for 10 cycles in RESP -> rsp_valid and rsp_vec stable, req_ready=0, busy=1 throughout.
REQ-024 The bench SHALL cover: reset asserted during DRIVE -> all outputs zero asynchronously, txn_cnt unchanged at 0, and no rsp_valid afterwards.
REQ-025 The bench SHALL cover: txn_cnt preloaded to 16'hFFFE, then 3 transactions -> txn_cnt reads 16'hFFFF and stays there.
REQ-026 The bench SHALL cover: only requester 1 valid with non-owner rsp_ready[0]=1 in RESP -> no completion until rsp_ready[1]=1.
